// File: rtl/mux_arbiter.sv
// Round-robin arbiter sharing the 4:1 mux datapath among four requesters.
// Issues a registered one-hot grant and drives the mux selects with a bounded hold tenure.
module mux_arbiter #(
    parameter  int unsigned MAX_HOLD = 4,
    localparam int unsigned CW       = $clog2(MAX_HOLD + 1)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic       S1,
    output logic       S0,
    output logic       busy,
    output logic       switch
);

    localparam int unsigned NREQ = 4;
    localparam int unsigned IW   = 2;
    localparam logic [CW-1:0] HOLD_MAX = CW'(MAX_HOLD);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   own_q, own_d;
    logic [IW-1:0]   last_q, last_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NREQ-1:0] gnt_d;
    logic            switch_d;
    logic [IW:0]     pick_idle, pick_drop, pick_rot;

    // First set bit searching upward from start, modulo 4; MSB of result flags a hit.
    function automatic logic [IW:0] rr_pick(input logic [NREQ-1:0] r, input logic [IW-1:0] start);
        logic [IW:0]   res;
        logic [IW-1:0] idx;
        res = '0;
        for (int i = int'(NREQ) - 1; i >= 0; i--) begin
            idx = start + IW'(i);
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    assign pick_idle = rr_pick(req, last_q + IW'(1));
    assign pick_drop = rr_pick(req, own_q + IW'(1));
    // Rotation at hold limit only considers the other requesters.
    assign pick_rot  = rr_pick(req & ~(NREQ'(1) << own_q), own_q + IW'(1));

    // Next-state and next-output logic.
    always_comb begin
        state_d  = state_q;
        own_d    = own_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        switch_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_idle[IW]) begin
                    state_d  = GRANT;
                    own_d    = pick_idle[IW-1:0];
                    last_d   = pick_idle[IW-1:0];
                    cnt_d    = CW'(1);
                    switch_d = 1'b1;
                end
            end
            GRANT: begin
                if (!req[own_q]) begin
                    if (pick_drop[IW]) begin
                        own_d    = pick_drop[IW-1:0];
                        last_d   = pick_drop[IW-1:0];
                        cnt_d    = CW'(1);
                        switch_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end else if (cnt_q < HOLD_MAX) begin
                    cnt_d = cnt_q + CW'(1);
                end else if (pick_rot[IW]) begin
                    own_d    = pick_rot[IW-1:0];
                    last_d   = pick_rot[IW-1:0];
                    cnt_d    = CW'(1);
                    switch_d = 1'b1;
                end else begin
                    cnt_d = CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        gnt_d = (state_d == GRANT) ? (NREQ'(1) << own_d) : '0;
    end

    // State and registered outputs; own_q doubles as the select register held through IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            own_q   <= '0;
            last_q  <= IW'(NREQ - 1);
            cnt_q   <= '0;
            gnt     <= '0;
            busy    <= 1'b0;
            switch  <= 1'b0;
        end else begin
            state_q <= state_d;
            own_q   <= own_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            gnt     <= gnt_d;
            busy    <= |gnt_d;
            switch  <= switch_d;
        end
    end

    assign S1 = own_q[1];
    assign S0 = own_q[0];

endmodule

// File: tb/tb_mux_arbiter.sv
// Self-checking bench for mux_arbiter: two instances (hold limit 4 and 1) against a tenure-level model.
module tb_mux_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0000;

    logic [3:0] gnt4, gnt1;
    logic       s1_4, s0_4, busy4, sw4;
    logic       s1_1, s0_1, busy1, sw1;

    int checks = 0;
    int failures = 0;

    int m_own[2];
    int m_ten[2];
    int m_last[2];
    int m_sel[2];
    int m_sw[2];
    int m_max[2];

    always #5 clk = ~clk;

    mux_arbiter #(.MAX_HOLD(4)) u_arb4 (
        .clk(clk), .rst_n(rst_n), .req(req),
        .gnt(gnt4), .S1(s1_4), .S0(s0_4), .busy(busy4), .switch(sw4)
    );

    mux_arbiter #(.MAX_HOLD(1)) u_arb1 (
        .clk(clk), .rst_n(rst_n), .req(req),
        .gnt(gnt1), .S1(s1_1), .S0(s0_1), .busy(busy1), .switch(sw1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_first(input logic [3:0] r, input int from);
        for (int i = 0; i < 4; i++) begin
            if (r[(from + i) % 4]) return (from + i) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_own[m]  = -1;
            m_ten[m]  = 0;
            m_last[m] = 3;
            m_sel[m]  = 0;
            m_sw[m]   = 0;
        end
    endtask

    task automatic model_take(input int m, input int w);
        m_own[m]  = w;
        m_ten[m]  = 1;
        m_last[m] = w;
        m_sel[m]  = w;
        m_sw[m]   = 1;
    endtask

    task automatic model_step(input logic [3:0] r);
        int w;
        logic [3:0] others;
        for (int m = 0; m < 2; m++) begin
            m_sw[m] = 0;
            if (m_own[m] < 0) begin
                w = rr_first(r, (m_last[m] + 1) % 4);
                if (w >= 0) model_take(m, w);
            end else if (!r[m_own[m]]) begin
                w = rr_first(r, (m_own[m] + 1) % 4);
                if (w >= 0) model_take(m, w);
                else m_own[m] = -1;
            end else if (m_ten[m] < m_max[m]) begin
                m_ten[m] = m_ten[m] + 1;
            end else begin
                others = r;
                others[m_own[m]] = 1'b0;
                w = rr_first(others, (m_own[m] + 1) % 4);
                if (w >= 0) model_take(m, w);
                else m_ten[m] = 1;
            end
        end
    endtask

    task automatic compare_all(input string where);
        logic [3:0] eg;
        logic [3:0] og;
        logic [1:0] os;
        logic       ob, ow;
        for (int m = 0; m < 2; m++) begin
            eg = (m_own[m] < 0) ? 4'b0000 : 4'(1 << m_own[m]);
            og = (m == 0) ? gnt4 : gnt1;
            os = (m == 0) ? {s1_4, s0_4} : {s1_1, s0_1};
            ob = (m == 0) ? busy4 : busy1;
            ow = (m == 0) ? sw4 : sw1;
            check($sformatf("%s_h%0d_gnt", where, m_max[m]), 32'(og), 32'(eg));
            check($sformatf("%s_h%0d_sel", where, m_max[m]), 32'(os), 32'(m_sel[m]));
            check($sformatf("%s_h%0d_busy", where, m_max[m]), 32'(ob), 32'(eg != 4'b0000));
            check($sformatf("%s_h%0d_switch", where, m_max[m]), 32'(ow), 32'(m_sw[m]));
        end
    endtask

    // Drive req at the falling edge, clock once, then compare both instances at the next falling edge.
    task automatic step(input logic [3:0] r, input string where);
        req = r;
        @(posedge clk);
        model_step(r);
        @(negedge clk);
        compare_all(where);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = 4'b1111;
        repeat (2) @(negedge clk);
        model_reset();
        check("rst_gnt4", 32'(gnt4), 32'h0);
        check("rst_sel4", 32'({s1_4, s0_4}), 32'h0);
        check("rst_busy4", 32'(busy4), 32'h0);
        check("rst_switch4", 32'(sw4), 32'h0);
        check("rst_gnt1", 32'(gnt1), 32'h0);
        rst_n = 1'b1;
        req   = 4'b0000;
    endtask

    initial begin
        int sw_count;
        logic [3:0] r;
        m_max[0] = 4;
        m_max[1] = 1;
        model_reset();

        // Reset with all requests high, then first grant goes to requester 0.
        do_reset();
        step(4'b1111, "first");
        check("first_gnt_req0", 32'(gnt4), 32'h1);

        // Single requester held for 12 cycles: one handover, no rotation.
        sw_count = 0;
        for (int i = 0; i < 12; i++) begin
            step(4'b0100, "single");
            sw_count += int'(sw4);
            check("single_gnt", 32'(gnt4), 32'h4);
            check("single_sel", 32'({s1_4, s0_4}), 32'h2);
        end
        check("single_switch_count", 32'(sw_count), 32'd1);

        // Full contention, hold limit 4.
        do_reset();
        for (int i = 0; i < 17; i++) begin
            step(4'b1111, "contend");
            check("contend_gnt_seq", 32'(gnt4), 32'(1 << ((i / 4) % 4)));
            check("contend_switch_seq", 32'(sw4), 32'((i % 4) == 0));
        end

        // Early release: owner 1 drops after 2 cycles while requester 3 waits.
        do_reset();
        step(4'b0010, "early");
        step(4'b1010, "early");
        check("early_owner1", 32'(gnt4), 32'h2);
        step(4'b1000, "handover");
        check("handover_gnt", 32'(gnt4), 32'h8);
        check("handover_busy", 32'(busy4), 32'h1);
        check("handover_switch", 32'(sw4), 32'h1);
        step(4'b0000, "release");
        check("release_gnt", 32'(gnt4), 32'h0);
        check("release_busy", 32'(busy4), 32'h0);
        check("release_sel_hold", 32'({s1_4, s0_4}), 32'h3);

        // Asynchronous reset mid-tenure of requester 2.
        do_reset();
        for (int i = 0; i < 3; i++) step(4'b0100, "pre_async");
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("async_gnt", 32'(gnt4), 32'h0);
        check("async_sel", 32'({s1_4, s0_4}), 32'h0);
        check("async_busy", 32'(busy4), 32'h0);
        check("async_switch", 32'(sw4), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step(4'b0100, "post_async");
        check("post_async_gnt", 32'(gnt4), 32'h4);
        check("post_async_switch", 32'(sw4), 32'h1);

        // Hold limit 1 alternates every cycle between two requesters.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(4'b0011, "hold1");
            check("hold1_gnt_alt", 32'(gnt1), 32'((i % 2 == 0) ? 1 : 2));
            check("hold1_switch", 32'(sw1), 32'h1);
        end

        // Randomised request streams with sticky bits.
        do_reset();
        r = 4'b0000;
        for (int i = 0; i < 400; i++) begin
            r = r ^ 4'($urandom & $urandom);
            step(r, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux_arbiter.md
# mux_arbiter

Round-robin arbiter that shares the 8-bit 4:1 `multiplexer` datapath of the ALU among four requesters. It samples a 4-bit request vector and issues a registered one-hot grant. It drives the multiplexer selects `S1`/`S0` to route the owner's `A<n>` input to `Y`. Tenure is bounded by a programmable hold limit so that no requester can starve the others.

## Interface
Parameters:
- `MAX_HOLD`, default 4: maximum consecutive granted cycles per tenure while other requests are pending; legal range 1..255.
- `CW`, default `$clog2(MAX_HOLD+1)`: hold-counter width; derived, not overridden.

Ports:
- `clk`  input  1  single clock, rising-edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `req`  input  4  request per requester; bit n means source `A<n>` wants `Y`.
- `gnt`  output  4  one-hot grant, registered; all zero when idle.
- `S1`  output  1  mux select MSB; `{S1,S0}` is the owner index.
- `S0`  output  1  mux select LSB.
- `busy`  output  1  high when any grant is active; equals `|gnt`.
- `switch`  output  1  one-cycle pulse in the first cycle of every new tenure.

## Operation
- Two states: IDLE (no grant) and GRANT (owner k; hold counter `cnt`).
- The round-robin pointer `last` holds the most recently granted index. Search priority is `last+1`, `last+2`, `last+3`, then `last`, modulo 4.
- Reset values:
  - `gnt` = 0000, `{S1,S0}` = 00, `busy` = 0, `switch` = 0.
  - `cnt` = 0, `last` = 3, so requester 0 has top priority. State is IDLE.
- IDLE:
  - If `req` ≠ 0, grant the first set bit in priority order. Go to GRANT, set `cnt` = 1, set `last` to the winner, pulse `switch`.
  - Otherwise stay in IDLE.
- GRANT, owner k:
  - `req[k]` = 0: re-arbitrate on the same edge over the current `req`, with priority starting at k+1.
    - Winner found: it takes ownership with `cnt` = 1 and `switch` pulses. There is no idle bubble.
    - No winner: go to IDLE.
  - `req[k]` = 1 and `cnt` < `MAX_HOLD`: keep owner k, `cnt` += 1.
  - `req[k]` = 1, `cnt` = `MAX_HOLD`, and another request pending: rotate to the next requester in priority order. Set `cnt` = 1 and pulse `switch`.
  - `req[k]` = 1, `cnt` = `MAX_HOLD`, and no other request: keep owner k and restart `cnt` = 1. `switch` does not pulse; this is not a new owner.
- `{S1,S0}` tracks the owner encoding. In IDLE it retains the last owner's index, so the mux does not toggle needlessly. `gnt` is zero in IDLE.
- `cnt` never exceeds `MAX_HOLD`. It is compared at full `CW` width with no wrap.
- Invariants: `gnt` is always one-hot or zero, and `busy` == `|gnt`.

## Timing
- Grant latency is one cycle: a `req` sampled high at edge t in IDLE produces `gnt`, `S1`/`S0`, `busy` and `switch` valid after edge t.
- `Y` is valid in the same cycle `gnt` is high, with combinational mux delay only.
- A requester must hold `req` until it observes `gnt`. It may drop `req` at any time and loses the grant at the next edge.
- Maximum tenure under contention is `MAX_HOLD` cycles. Worst-case wait for a pending requester is 3·`MAX_HOLD` cycles.
- Simultaneous owner drop and a new request are resolved on one edge; the new owner is chosen by rotating priority from k+1.
- Asserting `rst_n` low mid-tenure forces all outputs and state to reset values immediately, not waiting for `clk`. After deassertion, arbitration restarts from requester 0 priority.
- `req` changes are assumed synchronous to `clk`.

## Test plan
- Reset: hold `rst_n` = 0 with `req` = 1111 → `gnt` = 0000, `S1S0` = 00, `busy` = 0, `switch` = 0. After release, the first grant goes to requester 0.
- Single requester: `req` = 0100 held for 12 cycles → `gnt` = 0100 and `S1S0` = 10 from the next cycle, `switch` pulses once, no rotation; `Y` = `A2` throughout.
- Full contention, `MAX_HOLD` = 4: `req` = 1111 → `gnt` sequence 0001×4, 0010×4, 0100×4, 1000×4, 0001…; `switch` pulses every 4th cycle.
- Early release and handover:
  - Owner 1 drops `req` after 2 cycles while `req[3]` = 1 → `gnt` = 1000 on the next cycle, `busy` stays 1, `switch` pulses.
  - Then `req` = 0000 → `gnt` = 0000, `busy` = 0, `S1S0` holds 11.
- Asynchronous reset mid-tenure: owner 2 at `cnt` = 3, pull `rst_n` low between edges → outputs clear before the next edge. After release with `req` = 0100, requester 2 regains the grant with `cnt` = 1.
- `MAX_HOLD` = 1: `req` = 0011 → `gnt` alternates 0001/0010 every cycle and `switch` stays high each cycle.
